// File: rtl/l2_arb_pkg.sv
// Shared types and defaults for the L2 port arbiter.
package l2_arb_pkg;
    typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, LOCK_I, LOCK_D} arb_state_t;

    localparam logic RR_I       = 1'b0;
    localparam logic RR_D       = 1'b1;
    localparam int   ADDR_W_DEF = 30;
    localparam int   LINE_W_DEF = 128;
endpackage

// File: rtl/l2_arb_sat_cnt.sv
// Saturating up-counter for arbiter statistics; holds at all-ones instead of wrapping.
module l2_arb_sat_cnt
    import l2_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the L1 I-cache and D-cache.
//   state  | meaning
//   IDLE   | no owner; a requester is granted combinationally this cycle
//   GNT_I  | I owns the L2 port for one transaction
//   GNT_D  | D owns the L2 port for one transaction
//   LOCK_I | I keeps the port after a writeback for its refill
//   LOCK_D | D keeps the port after a writeback for its refill
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int CNT_W   = 16,
    parameter bit LOCK_WB = 1'b1,
    parameter bit FIRST_D = 1'b1
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              i_stall,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_ready,
    input  logic              l2_stall,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic [CNT_W-1:0]  i_wait_cnt,
    output logic [CNT_W-1:0]  d_wait_cnt
);
    arb_state_t r_state, w_next;
    logic       r_rr;
    logic       w_req_i, w_req_d;
    logic       w_hold, w_own_d, w_fwd, w_done, w_req_own, w_wr_own;
    logic       w_fwd_i, w_fwd_d;

    assign w_req_i = i_read | i_write;
    assign w_req_d = d_read | d_write;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state <= IDLE;
            r_rr    <= FIRST_D ? RR_D : RR_I;
        end else begin
            r_state <= w_next;
            if (w_done) begin
                r_rr <= w_own_d ? RR_I : RR_D;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_hold    = 1'b0;
        w_own_d   = 1'b0;
        w_fwd     = 1'b0;
        w_done    = 1'b0;
        w_req_own = 1'b0;
        w_wr_own  = 1'b0;
        case (r_state)
            IDLE: begin
                w_hold  = w_req_i | w_req_d;
                w_own_d = w_req_d & (~w_req_i | (r_rr == RR_D));
                w_fwd   = w_hold;
                if (w_hold) begin
                    w_next = w_own_d ? GNT_D : GNT_I;
                end
            end
            GNT_I, GNT_D, LOCK_I, LOCK_D: begin
                w_hold    = 1'b1;
                w_own_d   = (r_state == GNT_D) || (r_state == LOCK_D);
                w_req_own = w_own_d ? w_req_d : w_req_i;
                w_wr_own  = w_own_d ? d_write : i_write;
                // An aborted grant (request gone, no ready) forwards nothing.
                w_fwd     = w_req_own | l2_ready | (r_state == LOCK_I) | (r_state == LOCK_D);
                if (l2_ready) begin
                    w_done = 1'b1;
                    if (LOCK_WB && w_wr_own && ((r_state == GNT_I) || (r_state == GNT_D))) begin
                        w_next = w_own_d ? LOCK_D : LOCK_I;
                    end else begin
                        w_next = IDLE;
                    end
                end else if (!w_req_own) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        // No one is granted while reset is held, so the L2 side stays quiet.
        if (proc_reset) begin
            w_hold = 1'b0;
            w_fwd  = 1'b0;
            w_done = 1'b0;
        end
    end

    assign w_fwd_i = w_fwd & ~w_own_d;
    assign w_fwd_d = w_fwd & w_own_d;

    assign l2_read  = w_fwd & (w_own_d ? d_read : i_read);
    assign l2_write = w_fwd & (w_own_d ? d_write : i_write);
    assign l2_addr  = w_fwd ? (w_own_d ? d_addr : i_addr) : '0;
    assign l2_wdata = w_fwd ? (w_own_d ? d_wdata : i_wdata) : '0;

    assign i_rdata = w_fwd_i ? l2_rdata : '0;
    assign i_ready = w_fwd_i & (r_state != IDLE) & l2_ready;
    assign i_stall = w_fwd_i ? l2_stall : w_req_i;
    assign d_rdata = w_fwd_d ? l2_rdata : '0;
    assign d_ready = w_fwd_d & (r_state != IDLE) & l2_ready;
    assign d_stall = w_fwd_d ? l2_stall : w_req_d;

    l2_arb_sat_cnt #(.CNT_W(CNT_W)) u_i_grant (
        .clk(clk), .i_clr(proc_reset), .i_inc(w_done & ~w_own_d), .o_cnt(i_grant_cnt));
    l2_arb_sat_cnt #(.CNT_W(CNT_W)) u_d_grant (
        .clk(clk), .i_clr(proc_reset), .i_inc(w_done & w_own_d), .o_cnt(d_grant_cnt));
    l2_arb_sat_cnt #(.CNT_W(CNT_W)) u_i_wait (
        .clk(clk), .i_clr(proc_reset), .i_inc(w_hold & w_own_d & w_req_i), .o_cnt(i_wait_cnt));
    l2_arb_sat_cnt #(.CNT_W(CNT_W)) u_d_wait (
        .clk(clk), .i_clr(proc_reset), .i_inc(w_hold & ~w_own_d & w_req_d), .o_cnt(d_wait_cnt));
endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: two instances (writeback lock on / off with narrow counters)
// driven in parallel and compared against a transaction-level reference model.
module tb_l2_arbiter;
    logic         clk = 1'b0;
    logic         proc_reset;
    logic         i_read, i_write, d_read, d_write;
    logic [29:0]  i_addr, d_addr;
    logic [127:0] i_wdata, d_wdata, l2_rdata;
    logic         l2_ready, l2_stall;

    logic [127:0] a_i_rdata, a_d_rdata, a_l2_wdata, b_i_rdata, b_d_rdata, b_l2_wdata;
    logic         a_i_ready, a_i_stall, a_d_ready, a_d_stall, a_l2_read, a_l2_write;
    logic         b_i_ready, b_i_stall, b_d_ready, b_d_stall, b_l2_read, b_l2_write;
    logic [29:0]  a_l2_addr, b_l2_addr;
    logic [15:0]  a_i_gc, a_d_gc, a_i_wc, a_d_wc;
    logic [3:0]   b_i_gc, b_d_gc, b_i_wc, b_d_wc;
    logic [483:0] obs_a, obs_b, exp_a, exp_b;

    int checks = 0;
    int errors = 0;

    // Model: holder -1 none / 0 I / 1 D; rr holds the side that wins a tie.
    int m_hold[2] = '{-1, -1};
    bit m_lock[2] = '{1'b0, 1'b0};
    int m_rr[2]   = '{1, 1};
    int m_gc[2][2];
    int m_wc[2][2];

    always #5 clk = ~clk;

    l2_arbiter #(.CNT_W(16), .LOCK_WB(1'b1), .FIRST_D(1'b1)) dut_a (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(a_i_rdata), .i_ready(a_i_ready), .i_stall(a_i_stall),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(a_d_rdata), .d_ready(a_d_ready), .d_stall(a_d_stall),
        .l2_read(a_l2_read), .l2_write(a_l2_write), .l2_addr(a_l2_addr), .l2_wdata(a_l2_wdata),
        .l2_rdata(l2_rdata), .l2_ready(l2_ready), .l2_stall(l2_stall),
        .i_grant_cnt(a_i_gc), .d_grant_cnt(a_d_gc), .i_wait_cnt(a_i_wc), .d_wait_cnt(a_d_wc));

    l2_arbiter #(.CNT_W(4), .LOCK_WB(1'b0), .FIRST_D(1'b1)) dut_b (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(b_i_rdata), .i_ready(b_i_ready), .i_stall(b_i_stall),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(b_d_rdata), .d_ready(b_d_ready), .d_stall(b_d_stall),
        .l2_read(b_l2_read), .l2_write(b_l2_write), .l2_addr(b_l2_addr), .l2_wdata(b_l2_wdata),
        .l2_rdata(l2_rdata), .l2_ready(l2_ready), .l2_stall(l2_stall),
        .i_grant_cnt(b_i_gc), .d_grant_cnt(b_d_gc), .i_wait_cnt(b_i_wc), .d_wait_cnt(b_d_wc));

    assign obs_a = {a_l2_read, a_l2_write, a_l2_addr, a_l2_wdata, a_i_rdata, a_i_ready, a_i_stall,
                    a_d_rdata, a_d_ready, a_d_stall, a_i_gc, a_d_gc, a_i_wc, a_d_wc};
    assign obs_b = {b_l2_read, b_l2_write, b_l2_addr, b_l2_wdata, b_i_rdata, b_i_ready, b_i_stall,
                    b_d_rdata, b_d_ready, b_d_stall, 12'd0, b_i_gc, 12'd0, b_d_gc,
                    12'd0, b_i_wc, 12'd0, b_d_wc};

    function automatic int cnt_max(int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic bit lock_wb(int k);
        return (k == 0);
    endfunction

    function automatic bit req_of(int s);
        return (s == 1) ? (d_read | d_write) : (i_read | i_write);
    endfunction

    function automatic int cur_owner(int k);
        if (proc_reset) return -1;
        if (m_hold[k] >= 0) return m_hold[k];
        if (req_of(0) && req_of(1)) return m_rr[k];
        if (req_of(1)) return 1;
        if (req_of(0)) return 0;
        return -1;
    endfunction

    function automatic logic [483:0] model_out(int k);
        int           h;
        bit           fwd;
        bit           mine;
        logic         rd, wr;
        logic [29:0]  ad;
        logic [127:0] wd;
        logic [127:0] rdat[2];
        logic         rdy[2];
        logic         stl[2];
        h   = cur_owner(k);
        fwd = (h >= 0) && ((m_hold[k] < 0) || m_lock[k] || req_of(h) || l2_ready);
        rd  = 1'b0;
        wr  = 1'b0;
        ad  = '0;
        wd  = '0;
        if (fwd) begin
            rd = (h == 1) ? d_read : i_read;
            wr = (h == 1) ? d_write : i_write;
            ad = (h == 1) ? d_addr : i_addr;
            wd = (h == 1) ? d_wdata : i_wdata;
        end
        for (int s = 0; s < 2; s++) begin
            mine    = fwd && (h == s);
            rdat[s] = mine ? l2_rdata : '0;
            rdy[s]  = mine && (m_hold[k] >= 0) && l2_ready;
            stl[s]  = mine ? l2_stall : req_of(s);
        end
        return {rd, wr, ad, wd, rdat[0], rdy[0], stl[0], rdat[1], rdy[1], stl[1],
                16'(m_gc[k][0]), 16'(m_gc[k][1]), 16'(m_wc[k][0]), 16'(m_wc[k][1])};
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int h;
            bit idle;
            h    = cur_owner(k);
            idle = (m_hold[k] < 0);
            if (proc_reset) begin
                m_hold[k] = -1;
                m_lock[k] = 1'b0;
                m_rr[k]   = 1;
                for (int s = 0; s < 2; s++) begin
                    m_gc[k][s] = 0;
                    m_wc[k][s] = 0;
                end
            end else begin
                if (h >= 0 && req_of(1 - h) && m_wc[k][1-h] < cnt_max(k))
                    m_wc[k][1-h] = m_wc[k][1-h] + 1;
                if (idle) begin
                    m_hold[k] = h;
                    m_lock[k] = 1'b0;
                end else if (l2_ready) begin
                    if (m_gc[k][h] < cnt_max(k)) m_gc[k][h] = m_gc[k][h] + 1;
                    m_rr[k] = 1 - h;
                    if (!m_lock[k] && lock_wb(k) && ((h == 1) ? d_write : i_write)) begin
                        m_lock[k] = 1'b1;
                    end else begin
                        m_hold[k] = -1;
                        m_lock[k] = 1'b0;
                    end
                end else if (!req_of(h)) begin
                    m_hold[k] = -1;
                    m_lock[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        l2_rdata = '0; l2_ready = 0; l2_stall = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        proc_reset = 1;
        advance();
        advance();
        proc_reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        proc_reset = 1;
        i_read = 1;
        advance();
        #1;
        checks++;
        if ({a_l2_read, a_i_stall, a_i_gc, a_i_wc} !== {1'b0, 1'b1, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_held got=%h exp=%h", {a_l2_read, a_i_stall, a_i_gc, a_i_wc}, {1'b0, 1'b1, 32'd0});
        end
        do_reset();
        #1;
        checks++;
        if (obs_a !== '0) begin errors++; $display("FAIL reset_idle_a got=%h exp=0", obs_a); end
        checks++;
        if (obs_b !== '0) begin errors++; $display("FAIL reset_idle_b got=%h exp=0", obs_b); end
    endtask

    task automatic test_single_read();
        logic [127:0] pat;
        pat = {16{8'hA5}};
        do_reset();
        i_read = 1; i_addr = 30'h10;
        #1;
        checks++;
        if ({a_l2_read, a_l2_addr} !== {1'b1, 30'h10}) begin
            errors++; $display("FAIL single_fwd got=%h exp=%h", {a_l2_read, a_l2_addr}, {1'b1, 30'h10});
        end
        advance();
        l2_stall = 1;
        #1;
        checks++;
        if (a_i_stall !== 1'b1) begin errors++; $display("FAIL single_stall got=%b exp=1", a_i_stall); end
        advance();
        l2_stall = 0;
        advance();
        l2_ready = 1; l2_rdata = pat;
        #1;
        checks++;
        if ({a_i_ready, a_i_rdata, b_i_ready, b_i_rdata} !== {1'b1, pat, 1'b1, pat}) begin
            errors++; $display("FAIL single_ready got=%b/%h exp=1/%h", a_i_ready, a_i_rdata, pat);
        end
        advance();
        l2_ready = 0; i_read = 0;
        #1;
        checks++;
        if ({a_i_gc, b_i_gc} !== {16'd1, 4'd1}) begin
            errors++; $display("FAIL single_gcnt got=%0d/%0d exp=1/1", a_i_gc, b_i_gc);
        end
    endtask

    task automatic test_tie();
        int r;
        r = $urandom_range(5, 2);
        do_reset();
        i_read = 1; i_addr = 30'h20;
        d_read = 1; d_addr = 30'h30;
        for (int c = 0; c <= r; c++) begin
            l2_ready = (c == r);
            l2_rdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (c == 0) begin
                checks++;
                if ({a_l2_read, a_l2_addr} !== {1'b1, 30'h30}) begin
                    errors++; $display("FAIL tie_d_wins got=%h exp=%h", {a_l2_read, a_l2_addr}, {1'b1, 30'h30});
                end
            end
            checks++;
            if (a_i_stall !== 1'b1) begin errors++; $display("FAIL tie_i_stall cyc=%0d got=%b exp=1", c, a_i_stall); end
            advance();
        end
        l2_ready = 0; d_read = 0;
        #1;
        checks++;
        if ({a_l2_read, a_l2_addr, a_i_stall} !== {1'b1, 30'h20, 1'b0}) begin
            errors++; $display("FAIL tie_i_next got=%h exp=%h", {a_l2_read, a_l2_addr, a_i_stall}, {1'b1, 30'h20, 1'b0});
        end
        checks++;
        if (a_i_wc !== 16'(r + 1)) begin errors++; $display("FAIL tie_i_wait got=%0d exp=%0d", a_i_wc, r + 1); end
        advance();
        l2_ready = 1;
        advance();
        l2_ready = 0; i_read = 0;
        advance();
    endtask

    task automatic test_lock();
        do_reset();
        i_read = 1; i_addr = 30'h50;
        d_write = 1; d_addr = 30'h40; d_wdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        checks++;
        if ({a_l2_write, a_l2_addr, a_l2_wdata} !== {1'b1, 30'h40, d_wdata}) begin
            errors++; $display("FAIL lock_wr_fwd got=%h/%h", a_l2_addr, a_l2_wdata);
        end
        advance();
        l2_ready = 1;
        #1;
        checks++;
        if ({a_d_ready, b_d_ready} !== 2'b11) begin errors++; $display("FAIL lock_wr_ready got=%b%b exp=11", a_d_ready, b_d_ready); end
        advance();
        l2_ready = 0; d_write = 0; d_read = 1; d_addr = 30'h80;
        #1;
        checks++;
        if ({a_l2_read, a_l2_addr, a_i_stall} !== {1'b1, 30'h80, 1'b1}) begin
            errors++; $display("FAIL lock_a_keeps got=%h exp=%h", {a_l2_read, a_l2_addr, a_i_stall}, {1'b1, 30'h80, 1'b1});
        end
        checks++;
        if ({b_l2_read, b_l2_addr, b_i_stall} !== {1'b1, 30'h50, 1'b0}) begin
            errors++; $display("FAIL nolock_b_i got=%h exp=%h", {b_l2_read, b_l2_addr, b_i_stall}, {1'b1, 30'h50, 1'b0});
        end
        advance();
        l2_ready = 1;
        #1;
        checks++;
        if ({a_d_ready, a_i_stall} !== 2'b11) begin errors++; $display("FAIL lock_rd_ready got=%b%b exp=11", a_d_ready, a_i_stall); end
        advance();
        l2_ready = 0; d_read = 0;
        #1;
        checks++;
        if ({a_l2_read, a_l2_addr, a_d_gc, a_i_wc} !== {1'b1, 30'h50, 16'd2, 16'd4}) begin
            errors++; $display("FAIL lock_release got=%h exp=%h", {a_l2_read, a_l2_addr, a_d_gc, a_i_wc}, {1'b1, 30'h50, 16'd2, 16'd4});
        end
        i_read = 0;
        advance();
    endtask

    task automatic test_mid_reset();
        do_reset();
        i_read = 1; i_addr = 30'h60;
        #1;
        checks++;
        if (a_l2_addr !== 30'h60) begin errors++; $display("FAIL midrst_i_fwd got=%h exp=60", a_l2_addr); end
        advance();
        d_read = 1; d_addr = 30'h70;
        #1;
        checks++;
        if ({a_l2_addr, a_d_stall} !== {30'h60, 1'b1}) begin
            errors++; $display("FAIL midrst_d_pend got=%h exp=%h", {a_l2_addr, a_d_stall}, {30'h60, 1'b1});
        end
        advance();
        proc_reset = 1;
        advance();
        #1;
        checks++;
        if ({a_l2_read, a_l2_write, a_l2_addr, a_l2_wdata, a_d_stall} !== {160'd0, 1'b1}) begin
            errors++; $display("FAIL midrst_l2_quiet got=%h/%h", a_l2_addr, a_l2_wdata);
        end
        checks++;
        if ({a_i_gc, a_d_gc, a_i_wc, a_d_wc} !== 64'd0) begin
            errors++; $display("FAIL midrst_cnt got=%h exp=0", {a_i_gc, a_d_gc, a_i_wc, a_d_wc});
        end
        proc_reset = 0;
        advance();
        #1;
        checks++;
        if ({a_l2_read, a_l2_addr, a_i_stall} !== {1'b1, 30'h70, 1'b1}) begin
            errors++; $display("FAIL midrst_d_gnt got=%h exp=%h", {a_l2_read, a_l2_addr, a_i_stall}, {1'b1, 30'h70, 1'b1});
        end
        i_read = 0; d_read = 0;
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        d_read = 1; d_addr = 30'h90;
        i_read = 1; i_addr = 30'h91;
        l2_stall = 1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (c == 16) begin
                checks++;
                if (b_i_wc !== 4'hF) begin errors++; $display("FAIL sat_b_16 got=%0d exp=15", b_i_wc); end
            end
            advance();
        end
        #1;
        checks++;
        if ({b_i_wc, a_i_wc, b_d_stall} !== {4'hF, 16'd20, 1'b1}) begin
            errors++; $display("FAIL sat_final got=%0d/%0d/%b exp=15/20/1", b_i_wc, a_i_wc, b_d_stall);
        end
        clear_inputs();
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            i_read   = ($urandom % 3) == 0;
            i_write  = ($urandom % 5) == 0;
            d_read   = ($urandom % 3) == 0;
            d_write  = ($urandom % 4) == 0;
            i_addr   = 30'($urandom);
            d_addr   = 30'($urandom);
            i_wdata  = {$urandom, $urandom, $urandom, $urandom};
            d_wdata  = {$urandom, $urandom, $urandom, $urandom};
            l2_rdata = {$urandom, $urandom, $urandom, $urandom};
            l2_ready = ($urandom % 4) == 0;
            l2_stall = ($urandom % 2) == 0;
            proc_reset = ($urandom % 150) == 0;
            #1;
            exp_a = model_out(0);
            exp_b = model_out(1);
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL random_a cyc=%0d got=%h exp=%h", n, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL random_b cyc=%0d got=%h exp=%h", n, obs_b, exp_b); end
            advance();
        end
        proc_reset = 0;
    endtask

    initial begin
        clear_inputs();
        proc_reset = 1;
        test_reset();
        test_single_read();
        test_tie();
        test_lock();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
